// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
package seven_seg_pkg;

  localparam int unsigned MAX_DIGITS = 64;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;

  // Active-low one-hot anode word; bits at or above n stay high.
  function automatic logic [MAX_DIGITS-1:0] onehot_low(input int unsigned idx,
                                                       input int unsigned n);
    logic [MAX_DIGITS-1:0] word;
    word = '1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && (i == idx)) word[i] = 1'b0;
    end
    return word;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_scan_counter.sv
// Slot/digit timebase: tick counter per digit slot and digit index per frame.
module scan_counter #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_W     = 16,
  parameter int unsigned DIG_W      = $clog2(NUM_DIGITS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [DIG_W-1:0]  digit_idx_o,
  output logic [TICK_W-1:0] tick_cnt_o,
  output logic              frame_start_o,
  output logic              commit_o
);

  logic [TICK_W-1:0] r_tick;
  logic [DIG_W-1:0]  r_digit;
  logic              w_tick_max;
  logic              w_last_digit;

  assign w_tick_max   = &r_tick;
  assign w_last_digit = (r_digit == DIG_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick  <= '0;
      r_digit <= '0;
    end else begin
      r_tick <= r_tick + 1'b1;
      if (w_tick_max) begin
        r_digit <= w_last_digit ? '0 : r_digit + 1'b1;
      end
    end
  end

  assign digit_idx_o   = r_digit;
  assign tick_cnt_o    = r_tick;
  assign frame_start_o = (r_digit == '0) && (r_tick == '0);
  assign commit_o      = w_last_digit && w_tick_max;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver with frame-synchronous
// double-buffered contents, PWM brightness and a blank guard at each slot start.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SEG_W       = 8,
  parameter int unsigned TICK_W      = 16,
  parameter int unsigned BRIGHT_W    = 4,
  parameter int unsigned BLANK_TICKS = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]       enable_i,
  input  logic [BRIGHT_W-1:0]         brightness_i,
  input  logic                        update_i,
  output logic [NUM_DIGITS-1:0]       an_o,
  output logic [SEG_W-1:0]            hex_o,
  output logic                        frame_o
);

  localparam int unsigned DIG_W = $clog2(NUM_DIGITS);

  logic [DIG_W-1:0]            w_digit_idx;
  logic [TICK_W-1:0]           w_tick;
  logic                        w_frame_start;
  logic                        w_commit;

  logic [NUM_DIGITS*SEG_W-1:0] r_sh_digits, r_act_digits;
  logic [NUM_DIGITS-1:0]       r_sh_en, r_act_en;
  logic [BRIGHT_W-1:0]         r_sh_bright, r_act_bright;
  logic                        r_pending;

  logic [NUM_DIGITS-1:0]       r_an;
  logic [SEG_W-1:0]            r_hex;
  logic                        r_frame;

  logic [BRIGHT_W-1:0]         w_tick_hi;
  logic                        w_bright_ok;
  logic                        w_lit;
  logic [NUM_DIGITS-1:0]       w_an_sel;
  logic [SEG_W-1:0]            w_pattern;

  scan_counter #(
    .NUM_DIGITS (NUM_DIGITS),
    .TICK_W     (TICK_W),
    .DIG_W      (DIG_W)
  ) u_scan (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .digit_idx_o   (w_digit_idx),
    .tick_cnt_o    (w_tick),
    .frame_start_o (w_frame_start),
    .commit_o      (w_commit)
  );

  // An update landing on the commit cycle bypasses the shadow wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sh_digits  <= '1;
      r_sh_en      <= '0;
      r_sh_bright  <= '1;
      r_act_digits <= '1;
      r_act_en     <= '0;
      r_act_bright <= '1;
      r_pending    <= 1'b0;
    end else if (w_commit && update_i) begin
      r_sh_digits  <= digits_i;
      r_sh_en      <= enable_i;
      r_sh_bright  <= brightness_i;
      r_act_digits <= digits_i;
      r_act_en     <= enable_i;
      r_act_bright <= brightness_i;
      r_pending    <= 1'b0;
    end else if (w_commit && r_pending) begin
      r_act_digits <= r_sh_digits;
      r_act_en     <= r_sh_en;
      r_act_bright <= r_sh_bright;
      r_pending    <= 1'b0;
    end else if (update_i) begin
      r_sh_digits  <= digits_i;
      r_sh_en      <= enable_i;
      r_sh_bright  <= brightness_i;
      r_pending    <= 1'b1;
    end
  end

  assign w_tick_hi   = w_tick[TICK_W-1 -: BRIGHT_W];
  assign w_bright_ok = (&r_act_bright) || (w_tick_hi < r_act_bright);
  assign w_lit       = r_act_en[w_digit_idx]
                    && (w_tick >= TICK_W'(BLANK_TICKS))
                    && w_bright_ok;
  assign w_an_sel    = NUM_DIGITS'(onehot_low(int'(w_digit_idx), NUM_DIGITS));
  assign w_pattern   = r_act_digits[w_digit_idx*SEG_W +: SEG_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_an    <= '1;
      r_hex   <= '1;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_lit ? w_an_sel  : '1;
      r_hex   <= w_lit ? w_pattern : '1;
      r_frame <= w_frame_start;
    end
  end

  assign an_o    = r_an;
  assign hex_o   = r_hex;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised scoreboard bench for seven_seg_scanner against a cycle-count reference model.
module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int SW    = 8;
  localparam int TW    = 4;
  localparam int BW    = 2;
  localparam int BT    = 2;
  localparam int SLOT  = 1 << TW;
  localparam int FRAME = ND * SLOT;
  localparam int BDIV  = 1 << (TW - BW);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ND*SW-1:0]  digits = '1;
  logic [ND-1:0]     en = '0;
  logic [BW-1:0]     br = '1;
  logic              update = 1'b0;
  logic [ND-1:0]     an;
  logic [SW-1:0]     hex;
  logic              fr;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [SW-1:0] hex;
    logic          fr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state: cycles since reset release plus two content sets
  int          n;
  logic [7:0]  sh_d[ND], ac_d[ND], nw_d[ND];
  logic [ND-1:0] sh_en, ac_en;
  logic [BW-1:0] sh_br, ac_br;
  bit          pend;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .SEG_W       (SW),
    .TICK_W      (TW),
    .BRIGHT_W    (BW),
    .BLANK_TICKS (BT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .digits_i     (digits),
    .enable_i     (en),
    .brightness_i (br),
    .update_i     (update),
    .an_o         (an),
    .hex_o        (hex),
    .frame_o      (fr)
  );

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < ND; k++) begin
      sh_d[k] = 8'hFF;
      ac_d[k] = 8'hFF;
    end
    sh_en = '0; ac_en = '0;
    sh_br = '1; ac_br = '1;
    pend  = 1'b0;
    q.delete();
  endtask

  // reference model: predicts the registered outputs produced at each edge
  initial begin
    int d, t;
    bit lit, commit;
    exp_t e;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        d = (n / SLOT) % ND;
        t = n % SLOT;
        lit = ac_en[d] && (t >= BT) && ((ac_br == 2'b11) || ((t / BDIV) < int'(ac_br)));
        e.an  = lit ? ~(ND'(1) << d) : '1;
        e.hex = lit ? ac_d[d] : 8'hFF;
        e.fr  = (n % FRAME) == 0;
        q.push_back(e);
        commit = (n % FRAME) == FRAME - 1;
        for (int k = 0; k < ND; k++) nw_d[k] = digits[k*SW +: SW];
        if (commit && update) begin
          sh_d = nw_d; ac_d = nw_d;
          sh_en = en; ac_en = en;
          sh_br = br; ac_br = br;
          pend = 1'b0;
        end else if (commit && pend) begin
          ac_d = sh_d; ac_en = sh_en; ac_br = sh_br;
          pend = 1'b0;
        end else if (update) begin
          sh_d = nw_d; sh_en = en; sh_br = br;
          pend = 1'b1;
        end
        n++;
      end
    end
  end

  // monitor: compares DUT outputs mid-cycle against the predicted queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_chk++;
        if (an === '1 && hex === 8'hFF && fr === 1'b0) n_pass++;
        else $display("FAIL reset_hold: an_o=%b hex_o=%h frame_o=%b expected an=1111 hex=ff frame=0",
                      an, hex, fr);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (an === e.an && hex === e.hex && fr === e.fr) n_pass++;
        else $display("FAIL scoreboard t=%0t: an_o=%b hex_o=%h frame_o=%b expected an=%b hex=%h frame=%b",
                      $time, an, hex, fr, e.an, e.hex, e.fr);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic do_update(input logic [ND*SW-1:0] dg, input logic [ND-1:0] e,
                           input logic [BW-1:0] b);
    digits = dg; en = e; br = b; update = 1'b1;
    cycles(1);
    update = 1'b0;
  endtask

  // step to the cycle whose counter position within the frame is p
  task automatic wait_pos(input int p);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ((n % FRAME) == p) return;
      cycles(1);
    end
    n_chk++;
    $display("FAIL wait_pos timeout: position=%0d required=%0d", n % FRAME, p);
  endtask

  initial begin
    cycles(3);
    rst_n = 1'b1;
    cycles(FRAME + 10);

    do_update({8'hB0, 8'hA4, 8'hF9, 8'hC0}, 4'b1111, 2'b11);
    cycles(2 * FRAME);
    do_update({8'hB0, 8'hA4, 8'hF9, 8'hC0}, 4'b1111, 2'b01);
    cycles(2 * FRAME);
    do_update({8'hB0, 8'hA4, 8'hF9, 8'hC0}, 4'b0101, 2'b11);
    cycles(2 * FRAME);

    wait_pos(20);
    do_update({8'hB0, 8'hA4, 8'hF9, 8'h80}, 4'b1111, 2'b11);
    cycles(2 * FRAME);

    wait_pos(FRAME - 1);
    do_update({8'h92, 8'h99, 8'h82, 8'hF8}, 4'b1011, 2'b10);
    cycles(2 * FRAME);

    wait_pos(5);
    do_update({8'h11, 8'h22, 8'h33, 8'h44}, 4'b1111, 2'b11);
    cycles(10);
    do_update({8'h90, 8'h88, 8'h83, 8'hC6}, 4'b1110, 2'b11);
    cycles(2 * FRAME);

    do_update('0, 4'b0000, 2'b00);
    do_update('0, 4'b1111, 2'b00);
    cycles(2 * FRAME);

    for (int i = 0; i < 20; i++) begin
      cycles($urandom_range(1, 90));
      do_update({$urandom}, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    cycles(2 * FRAME + 10);

    do_update({8'hB0, 8'hA4, 8'hF9, 8'hC0}, 4'b1111, 2'b11);
    cycles(FRAME + 5);
    wait_pos(2 * SLOT + 7);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (an === '1 && hex === 8'hFF && fr === 1'b0) n_pass++;
    else $display("FAIL async_reset: an_o=%b hex_o=%h frame_o=%b expected an=1111 hex=ff frame=0",
                  an, hex, fr);
    cycles(3);
    rst_n = 1'b1;
    cycles(FRAME + 20);

    n_chk++;
    if (n_chk > 1500) n_pass++;
    else $display("FAIL check_volume: comparisons=%0d required>1500", n_chk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised time-multiplexed driver for a common-anode multi-digit display. It scans NUM_DIGITS segment patterns onto shared segment lines with per-digit enable, PWM brightness and an anti-ghosting blank guard. Display contents are double-buffered so that updates land only on frame boundaries and never tear. It sits between the display-formatting logic (BCD/hex-to-segment encoders) and the board pins, replacing the fixed 4-digit multiplexer.

## Interface
- NUM_DIGITS, 8: number of digits scanned, ≥2
- SEG_W, 8: segment bits per digit (7 segments + dp, active-low)
- TICK_W, 16: log2 of clock cycles per digit slot (slot = 2**TICK_W cycles)
- BRIGHT_W, 4: brightness control width
- BLANK_TICKS, 64: cycles at slot start with anodes forced off; < 2**TICK_W
- clk_i  in  1  system clock
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- digits_i  in  NUM_DIGITS*SEG_W  segment patterns; digit k at [k*SEG_W +: SEG_W], digit 0 rightmost
- enable_i  in  NUM_DIGITS  per-digit enable; 0 shows the digit blank
- brightness_i  in  BRIGHT_W  duty control; all-ones means 100 %
- update_i  in  1  single-cycle pulse: capture digits_i, enable_i and brightness_i into the shadow set
- an_o  out  NUM_DIGITS  anode drive, active-low, at most one bit low
- hex_o  out  SEG_W  segment drive, active-low
- frame_o  out  1  one-cycle pulse on the first cycle of each frame (digit 0, tick 0)

## Operation
- tick_cnt counts 0 … 2**TICK_W−1 and then wraps. On wrap, digit_idx increments and wraps from NUM_DIGITS−1 to 0.
- Frame: NUM_DIGITS consecutive slots. The frame ends at digit_idx = NUM_DIGITS−1 with tick_cnt all-ones (the commit cycle).
- Shadow set (digits, enable, brightness) loads on update_i and sets a pending flag.
- Active set is copied from the shadow on the commit cycle if pending is set; pending then clears.
- update_i on the commit cycle: the inputs go directly into both the shadow and active sets, and pending stays clear.
- Multiple update_i pulses within a frame: the last one wins.
- Lit condition for the current digit, all of which must hold:
  - enable bit set;
  - tick_cnt ≥ BLANK_TICKS;
  - brightness is all-ones, or tick_cnt[TICK_W−1 -: BRIGHT_W] < brightness.
- Brightness 0 gives a dark display.
- When lit: an_o has a single 0 at bit digit_idx, and hex_o shows that digit's active pattern.
- When not lit: an_o is all-ones and hex_o is all-ones. Segment lines are never driven while all anodes are off.
- Reset state:
  - counters 0;
  - shadow and active digits all-ones;
  - enable 0;
  - brightness all-ones;
  - pending 0;
  - an_o all-ones, hex_o all-ones, frame_o 0.
- Reset asserted mid-frame returns everything to the reset state immediately. The first frame_o pulse comes one cycle after release.

## Timing
- an_o, hex_o and frame_o are registered. Each reflects the counter state of the previous cycle (1-cycle latency).
- Committed content is first visible on the cycle after the frame_o pulse for the new frame.
- An update_i pulse becomes visible between 2 cycles and 1 frame + 2 cycles later.
- Anode transitions between digits always pass through ≥ BLANK_TICKS all-off cycles.
- Refresh rate = f_clk / (NUM_DIGITS · 2**TICK_W). With the defaults at 100 MHz this is about 190 Hz.

## Structure
- Package seven_seg_pkg holds:
  - constant SEG_BLANK (all-ones pattern);
  - function onehot_low(idx, n), returning the active-low one-hot anode word.
- Sub-module scan_counter holds tick_cnt and digit_idx, and outputs digit_idx, tick_cnt, frame_start and commit.
- Top level holds the shadow and active registers, the pending flag, the lit comparison and the output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, TICK_W=4, BRIGHT_W=2, BLANK_TICKS=2.
- Reset release, no update → an_o=4'b1111 and hex_o=8'hFF for a full frame; frame_o pulses every 64 cycles.
- update_i with digits {C0,F9,A4,B0}, enable=4'b1111, brightness=2'b11 → from the next frame, each slot shows an_o=1110,1101,1011,0111 with the matching pattern. Each slot is dark for 2 cycles, then lit for 14.
- brightness=2'b01, all digits enabled → each slot is lit only at ticks 2–3 and dark at ticks 0–1 and 4–15.
- enable=4'b0101 → slots 1 and 3 stay at an_o=1111, hex_o=FF; slots 0 and 2 are unchanged.
- update_i mid-frame with new digit 0 = 8'h80 → the old value persists to frame end, and 8'h80 appears in the next frame's slot 0. A pulse exactly on the commit cycle → appears in the very next frame.
- rst_ni pulsed low at digit 2, tick 7 → outputs go to all-ones asynchronously; after release, scanning restarts at digit 0 with contents blank.
